// File: rtl/alu_execute_unit_pkg.sv
// Shared ALU definitions: opcode enum, EX-stage FSM state type and opcode
// classification helpers. Imported by the ALU control decoder and by
// alu_execute_unit / alu_shifter.
package alu_execute_unit_pkg;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'b0000,
      ALU_SUB  = 4'b0001,
      ALU_AND  = 4'b0010,
      ALU_OR   = 4'b0011,
      ALU_XOR  = 4'b0100,
      ALU_SLL  = 4'b0101,
      ALU_SRL  = 4'b0110,
      ALU_SRA  = 4'b0111,
      ALU_SLT  = 4'b1000,
      ALU_SLTU = 4'b1001,
      ALU_BEQ  = 4'b1010,
      ALU_BNE  = 4'b1011,
      ALU_BLT  = 4'b1100,
      ALU_BGE  = 4'b1101,
      ALU_BLTU = 4'b1110,
      ALU_BGEU = 4'b1111
   } alu_op_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } alu_state_e;

   function automatic logic is_shift_op(input alu_op_e op);
      return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
   endfunction

   function automatic logic is_branch_op(input alu_op_e op);
      return (op == ALU_BEQ) || (op == ALU_BNE) || (op == ALU_BLT) ||
             (op == ALU_BGE) || (op == ALU_BLTU) || (op == ALU_BGEU);
   endfunction

endpackage

// File: rtl/alu_shifter.sv
// Shift engine for alu_execute_unit.
// ALU_BARREL_SHIFTER_EN defined : combinational barrel shift of a_i by shamt_i.
// ALU_BARREL_SHIFTER_EN undefined: one bit per cycle; start_i loads the
//   operand and count, done_o flags the cycle whose step is the last one and
//   result_o is the value the working register takes at that step.
module alu_shifter
   import alu_execute_unit_pkg::*;
#(
   parameter int unsigned XLEN = 32,
   localparam int unsigned SHW = $clog2(XLEN)
) (
   input  logic            clk,
   input  logic            rstN,
   input  logic            start_i,
   input  logic            flush_i,
   input  alu_op_e         op_i,
   input  logic [XLEN-1:0] a_i,
   input  logic [SHW-1:0]  shamt_i,
   output logic [XLEN-1:0] result_o,
   output logic            done_o
);

`ifdef ALU_BARREL_SHIFTER_EN

   // Single-cycle shift of the incoming operand
   always_comb begin
      case (op_i)
         ALU_SLL: result_o = a_i << shamt_i;
         ALU_SRL: result_o = a_i >> shamt_i;
         ALU_SRA: result_o = $unsigned($signed(a_i) >>> shamt_i);
         default: result_o = a_i;
      endcase
      done_o = 1'b1;
   end

`else

   logic [XLEN-1:0] work_q;
   logic [SHW-1:0]  cnt_q;
   alu_op_e         op_q;
   logic [XLEN-1:0] step;

   // One-bit step of the working register for the latched shift kind
   always_comb begin
      case (op_q)
         ALU_SLL: step = {work_q[XLEN-2:0], 1'b0};
         ALU_SRL: step = {1'b0, work_q[XLEN-1:1]};
         ALU_SRA: step = {work_q[XLEN-1], work_q[XLEN-1:1]};
         default: step = work_q;
      endcase
   end

   // Working register and remaining-shift counter
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         work_q <= '0;
         cnt_q  <= '0;
         op_q   <= ALU_ADD;
      end else if (flush_i) begin
         work_q <= '0;
         cnt_q  <= '0;
      end else if (start_i) begin
         work_q <= a_i;
         cnt_q  <= shamt_i;
         op_q   <= op_i;
      end else if (cnt_q != '0) begin
         work_q <= step;
         cnt_q  <= cnt_q - SHW'(1);
      end
   end

   assign result_o = step;
   assign done_o   = (cnt_q == SHW'(1));

`endif

endmodule

// File: rtl/alu_execute_unit.sv
// EX-stage ALU with valid/ready handshakes, registered result and branch
// decision. ALU_BARREL_SHIFTER_EN selects a single-cycle barrel shifter;
// otherwise shifts by a non-zero amount iterate one bit per cycle in SHIFT.
module alu_execute_unit
   import alu_execute_unit_pkg::*;
#(
   parameter int unsigned XLEN = 32
) (
   input  logic            clk,
   input  logic            rstN,
   input  logic            inValid,
   output logic            inReady,
   input  logic [3:0]      aluOp,
   input  logic [XLEN-1:0] operandA,
   input  logic [XLEN-1:0] operandB,
   input  logic            flush,
   output logic            outValid,
   input  logic            outReady,
   output logic [XLEN-1:0] aluResult,
   output logic            branchTaken,
   output logic            busy
);

   localparam int unsigned SHW = $clog2(XLEN);

   alu_state_e      state_q, state_d;
   logic [XLEN-1:0] result_q, result_d;
   logic            taken_q, taken_d;
   logic [XLEN-1:0] comp_res, sh_res;
   logic            comp_taken, sh_done;
   logic            take, iter_start;
   alu_op_e         op;
   logic [SHW-1:0]  shamt;

   assign op    = alu_op_e'(aluOp);
   assign shamt = operandB[SHW-1:0];
   // flush discards an operation offered in the same cycle
   assign take  = inValid && inReady && !flush;

`ifdef ALU_BARREL_SHIFTER_EN
   assign iter_start = 1'b0;
`else
   assign iter_start = take && is_shift_op(op) && (shamt != '0);
`endif

   alu_shifter #(.XLEN(XLEN)) u_shifter (
      .clk      (clk),
      .rstN     (rstN),
      .start_i  (iter_start),
      .flush_i  (flush),
      .op_i     (op),
      .a_i      (operandA),
      .shamt_i  (shamt),
      .result_o (sh_res),
      .done_o   (sh_done)
   );

   // Single-cycle result for every op that does not iterate
   always_comb begin
      comp_res   = '0;
      comp_taken = 1'b0;
      case (op)
         ALU_ADD:  comp_res = operandA + operandB;
         ALU_SUB:  comp_res = operandA - operandB;
         ALU_AND:  comp_res = operandA & operandB;
         ALU_OR:   comp_res = operandA | operandB;
         ALU_XOR:  comp_res = operandA ^ operandB;
`ifdef ALU_BARREL_SHIFTER_EN
         ALU_SLL, ALU_SRL, ALU_SRA: comp_res = sh_res;
`else
         ALU_SLL, ALU_SRL, ALU_SRA: comp_res = operandA;
`endif
         ALU_SLT:  comp_res = XLEN'($signed(operandA) < $signed(operandB));
         ALU_SLTU: comp_res = XLEN'(operandA < operandB);
         ALU_BEQ:  comp_taken = (operandA == operandB);
         ALU_BNE:  comp_taken = (operandA != operandB);
         ALU_BLT:  comp_taken = ($signed(operandA) < $signed(operandB));
         ALU_BGE:  comp_taken = ($signed(operandA) >= $signed(operandB));
         ALU_BLTU: comp_taken = (operandA < operandB);
         ALU_BGEU: comp_taken = (operandA >= operandB);
         default:  comp_res = '0;
      endcase
      if (is_branch_op(op)) comp_res = XLEN'(comp_taken);
   end

   // Result register next value: direct compute on accept, shifter on last step
   always_comb begin
      result_d = result_q;
      taken_d  = taken_q;
      if (flush) begin
         result_d = '0;
         taken_d  = 1'b0;
      end else if (take && !iter_start) begin
         result_d = comp_res;
         taken_d  = comp_taken;
      end else if ((state_q == ST_SHIFT) && sh_done) begin
         result_d = sh_res;
         taken_d  = 1'b0;
      end
   end

   // Result and branch-decision registers
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         result_q <= '0;
         taken_q  <= 1'b0;
      end else begin
         result_q <= result_d;
         taken_q  <= taken_d;
      end
   end

   // FSM state register
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   // FSM next state
   always_comb begin
      state_d = state_q;
      if (flush) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE, ST_DONE: begin
               if (take)                                  state_d = iter_start ? ST_SHIFT : ST_DONE;
               else if ((state_q == ST_DONE) && outReady) state_d = ST_IDLE;
            end
            ST_SHIFT: if (sh_done) state_d = ST_DONE;
            default:  state_d = ST_IDLE;
         endcase
      end
   end

   // FSM outputs
   always_comb begin
      inReady  = rstN && ((state_q == ST_IDLE) || ((state_q == ST_DONE) && outReady));
      outValid = (state_q == ST_DONE);
`ifdef ALU_BARREL_SHIFTER_EN
      busy     = 1'b0;
`else
      busy     = (state_q == ST_SHIFT);
`endif
   end

   assign aluResult   = result_q;
   assign branchTaken = taken_q;

endmodule
